// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer.
// Optional executed-cycle counter enabled by INSTR_SEQ_CYCLE_CNT_EN.
module instr_sequencer #(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic [8:0]      i_imem_data,
    input  logic            i_dec_reg_write,
    input  logic            i_dec_mem_read,
    input  logic            i_dec_mem_write,
    input  logic            i_dec_branch,
    input  logic            i_dec_halt,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_target,
    input  logic            i_mem_ack,
    output logic [PC_W-1:0] o_pc,
    output logic [8:0]      o_ir,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic            o_rf_we,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [15:0]     o_cycle_count
);
    localparam int TMO_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC,
        S_MEM, S_WB, S_HALTED, S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_pc_inc;
    logic [8:0]       r_ir;
    logic [8:0]       w_ir_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic             w_mem_op;
    logic             w_start_ok;

    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_mem_op   = i_dec_mem_read | i_dec_mem_write;
    assign w_start_ok = i_start & ((r_state == S_IDLE) |
                                   (r_state == S_HALTED) |
                                   (r_state == S_ERROR));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_tmo_nxt   = r_tmo;
        unique case (r_state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = '0;
                end
            end
            S_FETCH: begin
                w_ir_nxt    = i_imem_data;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (i_dec_halt) begin
                    w_state_nxt = S_HALTED;
                end else if (w_mem_op) begin
                    w_state_nxt = S_MEM;
                    w_tmo_nxt   = '0;
                end else if (i_dec_branch) begin
                    w_pc_nxt    = i_branch_taken ? i_branch_target : w_pc_inc;
                    w_state_nxt = S_FETCH;
                end else if (i_dec_reg_write) begin
                    w_state_nxt = S_WB;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                // An ack arriving on the final allowed cycle still completes the access
                if (i_mem_ack) begin
                    if (i_dec_mem_write) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_WB: begin
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_pc      = r_pc;
    assign o_ir      = r_ir;
    assign o_mem_req = (r_state == S_MEM);
    assign o_mem_we  = (r_state == S_MEM) & i_dec_mem_write;
    assign o_rf_we   = (r_state == S_WB);
    assign o_busy    = (r_state == S_FETCH) | (r_state == S_DECODE) |
                       (r_state == S_EXEC)  | (r_state == S_MEM) |
                       (r_state == S_WB);
    assign o_done    = (r_state == S_HALTED);
    assign o_err     = (r_state == S_ERROR);

`ifdef INSTR_SEQ_CYCLE_CNT_EN
    logic [15:0] r_cyc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cyc <= '0;
        end else if (w_start_ok) begin
            r_cyc <= '0;
        end else if (o_busy && (r_cyc != 16'hFFFF)) begin
            r_cyc <= r_cyc + 16'd1;
        end
    end

    assign o_cycle_count = r_cyc;
`else
    logic w_unused;
    assign w_unused      = w_start_ok;
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: trace model of instruction-level timing vs the DUT.
// Exercises INSTR_SEQ_CYCLE_CNT_EN expectations when that macro is defined.
module tb_instr_sequencer;
    localparam int TMO = 16;

    typedef struct {
        bit         start;
        bit         ack;
        logic [7:0] pc;
        bit         busy;
        bit         mreq;
        bit         mwe;
        bit         rfwe;
        bit         done;
        bit         err;
        logic [15:0] cyc;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic [8:0]  imem [256];
    logic [8:0]  imem_data;
    logic [7:0]  pc;
    logic [8:0]  ir;
    logic        mem_req, mem_we, rf_we, busy, done, err;
    logic [15:0] cyc;
    logic [2:0]  op;
    logic        d_rw, d_mr, d_mw, d_br, d_ht;

    int   checks = 0;
    int   failures = 0;
    row_t q[$];
    row_t cur;
    bit   cur_valid = 0;

    logic [7:0]  m_pc = 8'h00;
    int          m_mode = 0;
    logic [15:0] m_cyc = 16'h0000;

    // Bench-side decoder: opcode in IR[8:6], branch condition in IR[0]
    assign op   = ir[8:6];
    assign d_rw = (op == 3'd1) || (op == 3'd3) || (op == 3'd7);
    assign d_mr = (op == 3'd3);
    assign d_mw = (op == 3'd4) || (op == 3'd6);
    assign d_br = (op == 3'd2) || (op == 3'd7);
    assign d_ht = (op == 3'd5) || (op == 3'd6);
    assign imem_data = imem[pc];

    always #5 clk = ~clk;

    instr_sequencer #(.PC_W(8), .MEM_TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
        .i_imem_data(imem_data),
        .i_dec_reg_write(d_rw), .i_dec_mem_read(d_mr),
        .i_dec_mem_write(d_mw), .i_dec_branch(d_br), .i_dec_halt(d_ht),
        .i_branch_taken(ir[0]), .i_branch_target(br_target),
        .i_mem_ack(ack),
        .o_pc(pc), .o_ir(ir), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_rf_we(rf_we), .o_busy(busy), .o_done(done), .o_err(err),
        .o_cycle_count(cyc)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("pc", {8'h00, pc}, {8'h00, cur.pc});
            chk("busy", {15'd0, busy}, {15'd0, cur.busy});
            chk("mem_req", {15'd0, mem_req}, {15'd0, cur.mreq});
            chk("mem_we", {15'd0, mem_we}, {15'd0, cur.mwe});
            chk("rf_we", {15'd0, rf_we}, {15'd0, cur.rfwe});
            chk("done", {15'd0, done}, {15'd0, cur.done});
            chk("err", {15'd0, err}, {15'd0, cur.err});
`ifdef INSTR_SEQ_CYCLE_CNT_EN
            chk("cycle_count", cyc, cur.cyc);
`else
            chk("cycle_count", cyc, 16'h0000);
`endif
        end
    end

    task automatic push(input bit st, input bit ak, input bit bz,
                        input bit mq, input bit mw, input bit rw);
        row_t r;
        r.start = st; r.ack = ak; r.pc = m_pc; r.busy = bz;
        r.mreq = mq; r.mwe = mw; r.rfwe = rw;
        r.done = !bz && (m_mode == 1);
        r.err  = !bz && (m_mode == 2);
        r.cyc  = m_cyc;
        q.push_back(r);
        if (bz && m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
    endtask

    task automatic m_idle(input int n);
        for (int i = 0; i < n; i++) push(0, 0, 0, 0, 0, 0);
    endtask

    task automatic m_start();
        push(1, 0, 0, 0, 0, 0);
        m_pc = 8'h00; m_mode = 0; m_cyc = 16'h0000;
    endtask

    // One instruction from imem[m_pc]; waits = ack-free MEM cycles before ack
    task automatic m_instr(input int waits);
        logic [8:0] w;
        logic [2:0] o;
        bit rw, mr, mw, br, ht;
        w  = imem[m_pc];
        o  = w[8:6];
        rw = (o == 3'd1) || (o == 3'd3) || (o == 3'd7);
        mr = (o == 3'd3);
        mw = (o == 3'd4) || (o == 3'd6);
        br = (o == 3'd2) || (o == 3'd7);
        ht = (o == 3'd5) || (o == 3'd6);
        push(0, 1, 1, 0, 0, 0);
        push(1, 0, 1, 0, 0, 0);
        push(0, 0, 1, 0, 0, 0);
        if (ht) begin
            m_mode = 1;
        end else if (mr || mw) begin
            for (int i = 0; i < TMO; i++) begin
                if (i == waits) begin
                    push(0, 1, 1, 1, mw, 0);
                    if (!mw) push(0, 0, 1, 0, 0, 1);
                    m_pc = m_pc + 8'd1;
                    break;
                end
                push(0, 0, 1, 1, mw, 0);
                if (i == TMO - 1) m_mode = 2;
            end
        end else if (br) begin
            m_pc = w[0] ? br_target : m_pc + 8'd1;
        end else if (rw) begin
            push(0, 0, 1, 0, 0, 1);
            m_pc = m_pc + 8'd1;
        end else begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic run_q();
        while (q.size() > 0) begin
            cur = q.pop_front();
            start = cur.start;
            ack = cur.ack;
            cur_valid = 1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        cur_valid = 0;
        start = 0;
        ack = 0;
    endtask

    task automatic clr_imem();
        for (int i = 0; i < 256; i++) imem[i] = 9'h000;
    endtask

    function automatic int cnt_mreq();
        int n = 0;
        foreach (q[i]) if (q[i].mreq) n++;
        return n;
    endfunction

    function automatic int cnt_rfwe();
        int n = 0;
        foreach (q[i]) if (q[i].rfwe) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_imem();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", {8'h00, pc}, 16'h0000);
        chk("rst_ir", {7'd0, ir}, 16'h0000);
        chk("rst_flags", {10'd0, mem_req, mem_we, rf_we, busy, done, err},
            16'h0000);
        chk("rst_cyc", cyc, 16'h0000);
        rst_n = 1;
        m_idle(3);
        run_q();

        // ALU then HALT
        imem[0] = 9'h040;
        imem[1] = 9'h140;
        m_start(); m_instr(0); m_instr(0); m_idle(2);
        chk("model_alu_wb", {15'd0, q[4].rfwe}, 16'h0001);
        chk("model_alu_exec", {15'd0, q[3].rfwe}, 16'h0000);
        chk("model_alu_pc", {8'h00, q[5].pc}, 16'h0001);
        run_q();
        chk("alu_pc", {8'h00, pc}, 16'h0001);
        chk("alu_done", {15'd0, done}, 16'h0001);

        // Branch at PC 5, taken then not taken; op7 branch beats reg-write
        clr_imem();
        br_target = 8'h20;
        imem[5] = 9'h081;
        imem[8'h20] = 9'h140;
        m_start();
        for (int i = 0; i < 7; i++) m_instr(0);
        m_idle(2);
        run_q();
        chk("br_taken_pc", {8'h00, pc}, 16'h0020);
        imem[5] = 9'h080;
        imem[6] = 9'h1C0;
        imem[7] = 9'h140;
        m_start();
        for (int i = 0; i < 8; i++) m_instr(0);
        m_idle(2);
        chk("model_br_rfwe", cnt_rfwe(), 16'h0000);
        run_q();
        chk("br_not_taken_pc", {8'h00, pc}, 16'h0007);

        // Load with 3 wait cycles, store with none
        clr_imem();
        imem[0] = 9'h0C0;
        imem[1] = 9'h100;
        imem[2] = 9'h140;
        m_start(); m_instr(3); m_instr(0); m_instr(0); m_idle(2);
        chk("model_ldst_mreq", cnt_mreq(), 16'd5);
        chk("model_ld_rfwe", cnt_rfwe(), 16'd1);
        run_q();
        chk("ldst_pc", {8'h00, pc}, 16'h0002);

        // Ack on last allowed cycle, then a store that never completes
        clr_imem();
        imem[0] = 9'h100;
        imem[1] = 9'h100;
        imem[2] = 9'h140;
        m_start(); m_instr(TMO - 1); m_instr(999); m_idle(2);
        chk("model_tmo_mreq", cnt_mreq(), 16'd32);
        run_q();
        chk("tmo_err", {15'd0, err}, 16'h0001);
        chk("tmo_mreq", {15'd0, mem_req}, 16'h0000);
        chk("tmo_pc", {8'h00, pc}, 16'h0001);
        m_start(); m_instr(0); m_instr(0); m_instr(0); m_idle(2);
        run_q();
        chk("restart_done", {15'd0, done}, 16'h0001);

        // Halt beats memory write at 8'hFF; then wrap from 8'hFF to 0
        clr_imem();
        br_target = 8'hFF;
        imem[0] = 9'h081;
        imem[8'hFF] = 9'h180;
        m_start(); m_instr(0); m_instr(0); m_idle(2);
        chk("model_halt_mreq", cnt_mreq(), 16'd0);
        run_q();
        chk("halt_pc", {8'h00, pc}, 16'h00FF);
        chk("halt_done", {15'd0, done}, 16'h0001);
        imem[8'hFF] = 9'h040;
        m_start(); m_instr(0); m_instr(0);
        push(0, 0, 1, 0, 0, 0);
        run_q();
        chk("wrap_pc", {8'h00, pc}, 16'h0000);
        chk("wrap_busy", {15'd0, busy}, 16'h0001);

        // Reset while in MEM
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        m_pc = 8'h00; m_mode = 0; m_cyc = 16'h0000;
        clr_imem();
        imem[0] = 9'h0C0;
        m_start();
        push(0, 0, 1, 0, 0, 0);
        push(0, 0, 1, 0, 0, 0);
        push(0, 0, 1, 0, 0, 0);
        push(0, 0, 1, 1, 0, 0);
        push(0, 0, 1, 1, 0, 0);
        run_q();
        chk("pre_rst_mreq", {15'd0, mem_req}, 16'h0001);
        #2;
        rst_n = 0;
        #1;
        chk("rst_mem_mreq", {15'd0, mem_req}, 16'h0000);
        chk("rst_mem_busy", {15'd0, busy}, 16'h0000);
        chk("rst_mem_pc", {8'h00, pc}, 16'h0000);
        chk("rst_mem_ir", {7'd0, ir}, 16'h0000);
        chk("rst_mem_cyc", cyc, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        m_pc = 8'h00; m_mode = 0; m_cyc = 16'h0000;
        m_idle(4);
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_W, 8, program counter width in bits.
REQ-002 Parameter MEM_TIMEOUT, 16, maximum cycles in MEM awaiting MEM_ACK before ERROR.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  begin execution at PC 0; sampled only in IDLE, HALTED or ERROR.
REQ-006 IMEM_DATA  input  9  instruction word at address PC, combinational instruction memory.
REQ-007 DEC_REG_WRITE, DEC_MEM_READ, DEC_MEM_WRITE, DEC_BRANCH, DEC_HALT  input  1 each  decoder flags for IR.
REQ-008 BRANCH_TAKEN  input  1  datapath branch condition for IR.
REQ-009 BRANCH_TARGET  input  PC_W  branch destination address.
REQ-010 MEM_ACK  input  1  data memory completion.
REQ-011 PC  output  PC_W  current instruction address.
REQ-012 IR  output  9  latched instruction, feeds decoder OPCODE.
REQ-013 MEM_REQ  output  1  data memory request, held until ack.
REQ-014 MEM_WE  output  1  write qualifier, valid while MEM_REQ=1.
REQ-015 RF_WE  output  1  register file write strobe, one cycle.
REQ-016 BUSY  output  1  high in FETCH, DECODE, EXEC, MEM, WB.
REQ-017 DONE  output  1  high in HALTED.
REQ-018 ERR  output  1  high in ERROR.
REQ-019 CYCLE_COUNT  output  16  executed-cycle counter (see Configuration).

Function
REQ-020 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR; exactly one active.
REQ-021 IDLE/HALTED/ERROR + START=1 -> FETCH, PC<=0; else hold.
REQ-022 FETCH: IR<=IMEM_DATA; -> DECODE (one cycle).
REQ-023 DECODE: decoder flags settle from IR; no state updates; -> EXEC.
REQ-024 EXEC priority: DEC_HALT > (DEC_MEM_READ|DEC_MEM_WRITE) > DEC_BRANCH > DEC_REG_WRITE > none.
REQ-025 EXEC halt: -> HALTED, PC unchanged.
REQ-026 EXEC memory op: -> MEM, timeout counter cleared.
REQ-027 EXEC branch: PC<=BRANCH_TAKEN ? BRANCH_TARGET : PC+1; -> FETCH.
REQ-028 EXEC reg-write only: -> WB; no flags: PC<=PC+1, -> FETCH.
REQ-029 MEM: MEM_REQ=1, MEM_WE=DEC_MEM_WRITE; counter increments each cycle without ack.
REQ-030 MEM + MEM_ACK: load -> WB; store -> PC<=PC+1, FETCH.
REQ-031 MEM without ack when counter reaches MEM_TIMEOUT-1 -> ERROR; ack on that same cycle wins.
REQ-032 WB: RF_WE=1 for exactly one cycle, PC<=PC+1; -> FETCH.
REQ-033 Latency FETCH-to-FETCH: ALU 4, branch 3, store 4+wait, load 5+wait cycles.
REQ-034 PC+1 wraps modulo 2^PC_W (max -> 0), no flag.
REQ-035 MEM_ACK outside MEM ignored; START while BUSY ignored.
REQ-036 MEM_REQ, MEM_WE, RF_WE are 0 in every state not listed above.

Reset
REQ-037 RESET_N=0 asynchronously forces IDLE, PC=0, IR=0, counters=0, all 1-bit outputs 0.
REQ-038 Reset mid-MEM drops MEM_REQ immediately; no RF_WE issued for the aborted instruction.
REQ-039 After RESET_N rises, block stays IDLE until START.

Configuration
REQ-040 Macro INSTR_SEQ_CYCLE_CNT_EN defined: CYCLE_COUNT increments each cycle BUSY=1, saturates at 16'hFFFF, clears on START acceptance and reset.
REQ-041 Macro undefined: CYCLE_COUNT tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-042 Reset, START, IMEM add (REG_WRITE=1) -> FETCH,DECODE,EXEC,WB; RF_WE one pulse cycle 4; PC 0->1.
REQ-043 Branch at PC 5, TAKEN=1, TARGET=8'h20 -> PC=8'h20 after 3 cycles; TAKEN=0 -> PC=6.
REQ-044 Load, MEM_ACK after 3 wait cycles -> MEM_REQ high 4 cycles, MEM_WE=0, then RF_WE pulse, PC+1.
REQ-045 Store, MEM_ACK never -> ERR=1 after 16 MEM cycles, MEM_REQ=0; START -> FETCH at PC 0.
REQ-046 DEC_HALT=1 with DEC_MEM_WRITE=1 at PC 8'hFF -> HALTED, DONE=1, no MEM_REQ, PC=8'hFF; non-halt at 8'hFF wraps PC to 0.
REQ-047 RESET_N low mid-MEM -> IDLE, MEM_REQ=0 same cycle; with INSTR_SEQ_CYCLE_CNT_EN, CYCLE_COUNT=0.
